dm_access_ctrl: RTL and testbench

Multi-cycle data-memory access controller for the MEM stage of the MIPS pipeline. It accepts a load/store from the pipeline, stalls the pipeline through `busy` for a fixed access latency, then commits the write or returns the read word. Each instruction, identified by its `pc`, is serviced exactly once, so the pipeline proceeds once the stall drops.

---
 rtl/dm_access_ctrl_pkg.sv | 17 +
 rtl/dm_access_ctrl_if.sv | 25 ++
 rtl/dm_access_ctrl_ram.sv | 29 ++
 rtl/dm_access_ctrl.sv | 133 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } dm_state_t;

  typedef enum logic {
    DM_OP_READ  = 1'b0,
    DM_OP_WRITE = 1'b1
  } dm_op_t;

  localparam int unsigned DM_LATENCY = 2;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Pipeline-side request/response bundle of the data-memory access controller.
interface dm_access_ctrl_if;
  import dm_pkg::*;

  logic [31:0] pc;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        busy;
  logic [31:0] rdata;
  logic        done;

  modport master (
    output pc, memread, memwrite, addr, wdata, be,
    input  busy, rdata, done
  );

  modport slave (
    input  pc, memread, memwrite, addr, wdata, be,
    output busy, rdata, done
  );

endinterface

// File: rtl/dm_access_ctrl_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dm_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read-first: a write cycle returns the old word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store controller: stalls the pipeline for a fixed latency and
// services each instruction (identified by its pc) exactly once.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = DM_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  dm_access_ctrl_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dm_state_t         state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  dm_op_t            op_q, op_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;

  logic              req;
  logic [AW-1:0]     idx;
  logic              idle_like;
  logic              busy;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_rdata;
  logic              unused_addr;

  assign req         = bus.memread | bus.memwrite;
  assign idx         = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // HOLD releases into IDLE behaviour in the same cycle pc moves on or req drops.
  assign idle_like = (state_q == IDLE) ||
                     ((state_q == HOLD) && (!req || (bus.pc != pc_q)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    op_d     = op_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    busy     = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = idx_q;

    if (idle_like) begin
      busy    = req;
      state_d = IDLE;
      if (req) begin
        pc_d     = bus.pc;
        op_d     = bus.memwrite ? DM_OP_WRITE : DM_OP_READ;
        idx_d    = idx;
        wdata_d  = bus.wdata;
        be_d     = bus.be;
        cnt_d    = CNTW'(LATENCY - 1);
        state_d  = WAIT;
        // Read issued at WAIT entry so the word is ready when cnt reaches 0.
        ram_en   = 1'b1;
        ram_addr = idx;
      end
    end else if (state_q == WAIT) begin
      busy   = 1'b1;
      ram_en = 1'b1;
      if (!req || (bus.pc != pc_q)) begin
        state_d = IDLE;
      end else if (cnt_q == '0) begin
        if (op_q == DM_OP_WRITE) ram_we = be_q;
        else                     rdata_d = ram_rdata;
        done_d  = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (reset) ram_we = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      op_q    <= DM_OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  dm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.busy  = busy;
  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with LATENCY=2 and DEPTH_WORDS=1024.
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and follows it until busy drops (bounded).
  task automatic do_access(input logic [31:0] p, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output int nbusy, output int ndone);
    bus.pc       = p;
    bus.memwrite = wr;
    bus.memread  = !wr;
    bus.addr     = a;
    bus.wdata    = d;
    bus.be       = b;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.done === 1'b1) ndone++;
      if (bus.busy !== 1'b1) break;
      nbusy++;
      tick();
    end
  endtask

  task automatic store_chk(input string tag, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
    int nb, nd;
    do_access(p, 1'b1, a, d, b, nb, nd);
    check({tag, " busy cycles"}, nb, 3);
    check({tag, " done pulses"}, nd, 1);
    tick();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] exp);
    int nb, nd;
    do_access(p, 1'b0, a, 32'h0, 4'h0, nb, nd);
    check({tag, " busy cycles"}, nb, 3);
    check({tag, " done pulses"}, nd, 1);
    check({tag, " rdata"}, bus.rdata, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hb, dn, nb, nd;

    // Reset with a concurrent request: reset must win.
    reset        = 1'b1;
    bus.pc       = 32'h0;
    bus.memread  = 1'b1;
    bus.memwrite = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    bus.be       = 4'h0;
    tick();
    tick();
    reset       = 1'b0;
    bus.memread = 1'b0;
    #1;
    check("reset busy", bus.busy, 0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset done", bus.done, 0);
    tick();

    store_chk("store 0x10", 32'h100, 32'h10, 32'hDEADBEEF, 4'hF);
    load_chk("load 0x10", 32'h104, 32'h10, 32'hDEADBEEF);

    store_chk("store full 0x20", 32'h108, 32'h20, 32'h11223344, 4'hF);
    store_chk("store be0101 0x20", 32'h10C, 32'h20, 32'hAABBCCDD, 4'b0101);
    load_chk("load merged 0x20", 32'h110, 32'h20, 32'h11BB33DD);

    // Same pc held with memread high: no re-issue.
    load_chk("load before hold", 32'h114, 32'h10, 32'hDEADBEEF);
    hb = 0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.busy === 1'b1) hb++;
      if (bus.done === 1'b1) dn++;
      tick();
    end
    check("hold busy count", hb, 0);
    check("hold done count", dn, 0);
    check("hold rdata", bus.rdata, 32'hDEADBEEF);
    do_access(32'h118, 1'b0, 32'h20, 32'h0, 4'h0, nb, nd);
    check("pc change busy cycles", nb, 3);
    check("pc change done pulses", nd, 1);
    check("pc change rdata", bus.rdata, 32'h11BB33DD);
    tick();

    // Flush: store abandoned during WAIT.
    bus.pc       = 32'h11C;
    bus.memwrite = 1'b1;
    bus.memread  = 1'b0;
    bus.addr     = 32'h10;
    bus.wdata    = 32'h55555555;
    bus.be       = 4'hF;
    #1;
    check("flush start busy", bus.busy, 1);
    tick();
    bus.memwrite = 1'b0;
    tick();
    hb = 0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.busy === 1'b1) hb++;
      if (bus.done === 1'b1) dn++;
      tick();
    end
    check("flush busy count", hb, 0);
    check("flush done count", dn, 0);
    load_chk("load after flush", 32'h120, 32'h10, 32'hDEADBEEF);

    // Reset in the would-be commit cycle of a store.
    bus.pc       = 32'h124;
    bus.memwrite = 1'b1;
    bus.memread  = 1'b0;
    bus.addr     = 32'h10;
    bus.wdata    = 32'h77777777;
    bus.be       = 4'hF;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.memwrite = 1'b0;
    #1;
    check("mid reset busy", bus.busy, 0);
    check("mid reset rdata", bus.rdata, 32'h0);
    check("mid reset done", bus.done, 0);
    tick();
    load_chk("load after reset", 32'h128, 32'h10, 32'hDEADBEEF);

    // Word index wraps modulo 1024 words.
    store_chk("store 0x1000", 32'h12C, 32'h1000, 32'hCAFEF00D, 4'hF);
    load_chk("load wrap 0x0", 32'h130, 32'h0, 32'hCAFEF00D);
    load_chk("load 0x10 intact", 32'h134, 32'h10, 32'hDEADBEEF);

    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
